// File: rtl/data_memory_unit.sv
// Multi-cycle 64-bit doubleword data memory stage (LDUR/STUR) with a valid/ready request
// handshake, fixed wait latency, one-cycle response strobe and rejection of bad requests.
//
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | counting down wait cycles; memory is touched on the terminal count
//   RESP   | resp_valid strobe, error qualifies it
module data_memory_unit #(
   parameter int ADDR_BITS = 6,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [63:0] address,
   input  logic [63:0] write_data,
   output logic        resp_valid,
   output logic [63:0] read_data,
   output logic        error
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           counter;
   logic [ADDR_BITS-1:0] idx_q;
   logic                 rd_q;
   logic                 wr_q;
   logic [63:0]          wdata_q;
   logic [63:0]          mem [2**ADDR_BITS];

   logic accept;
   logic misaligned;
   logic out_of_range;
   logic illegal;
   logic bad;
   logic done;

   assign accept       = req_valid && req_ready;
   assign misaligned   = |address[2:0];
   assign out_of_range = |address[63:ADDR_BITS+3];
   assign illegal      = mem_read && mem_write;
   assign bad          = misaligned || out_of_range || illegal;
   assign done         = (state == ACCESS) && (counter == 4'd0);

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bad ? RESP : ACCESS;
         ACCESS:  if (done)   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter   <= 4'd0;
         idx_q     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= 64'd0;
         read_data <= 64'd0;
         error     <= 1'b0;
      end else begin
         if (accept) begin
            idx_q   <= address[ADDR_BITS+2:3];
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            wdata_q <= write_data;
            error   <= bad;
            counter <= 4'(LATENCY - 1);
         end
         if (state == ACCESS && counter != 4'd0) counter <= counter - 4'd1;
         if (done && rd_q) read_data <= mem[idx_q];
         if (state == RESP) error <= 1'b0;
      end
   end

   // Array has no reset: contents survive rst, but a store aborted by rst never lands.
   always_ff @(posedge clk) begin
      if (!rst && done && wr_q) mem[idx_q] <= wdata_q;
   end

endmodule
